complex_dot_product_feeder: RTL and testbench

Transmit-side controller for the conjugate complex dot-product engine. It buffers two complex vectors of NOE elements written by the host, resets the engine, and pulses the engine's read strobe. It streams the vectors as zero-padded NI-element packages in the two-phase (upper half, lower half) cadence the engine consumes, then waits for the engine's `finish`, captures the scalar result and reports completion to the host.

---
 rtl/complex_dot_product_feeder.sv | 181 ++++++++++++++++++
 tb/tb_complex_dot_product_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_dot_product_feeder.sv
// Buffers two complex vectors, fires the dot-product engine and streams zero-padded packages.
// Optional watchdog on the wait-for-finish state is enabled by defining FEEDER_TIMEOUT_EN.
module complex_dot_product_feeder #(
  parameter int unsigned element_width = 64,
  parameter int unsigned NOE           = 8,
  parameter int unsigned NI            = 8,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic                          wr_row,
  input  logic [$clog2(NOE)-1:0]        wr_addr,
  input  logic [element_width-1:0]      wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic [element_width*NI-1:0]   first_row_input,
  output logic [element_width*NI-1:0]   second_row_input,
  output logic                          outsider_read_now,
  output logic                          engine_reset,
  input  logic                          finish,
  input  logic [element_width-1:0]      dot_product_output,
  output logic [element_width-1:0]      result,
  output logic                          done,
  output logic                          timeout_err
);

  localparam int unsigned AddrW = $clog2(NOE);
  localparam int unsigned BusW  = element_width * NI;
  // One extra all-zero package when NOE divides evenly, matching the engine's total.
  localparam int unsigned P     = (NOE + NI - (NOE % NI)) / NI;
  localparam int unsigned PkgW  = (P > 1) ? $clog2(P) : 1;

  if (((NI % 2) != 0) || (TIMEOUT == 0)) begin : g_param_check
    $error("complex_dot_product_feeder: NI must be even and TIMEOUT non-zero");
  end

  typedef enum logic [2:0] {StIdle, StEngRst, StFire, StStream, StWaitFin} state_e;

  state_e                     state_q, state_d;
  logic [PkgW-1:0]            pkg_q, pkg_d;
  logic                       phase_q, phase_d;
  logic                       load;
  logic [PkgW-1:0]            load_idx;
  logic [BusW-1:0]            bus_a_q, bus_b_q;
  logic [BusW-1:0]            pack_a, pack_b;
  logic [element_width-1:0]   result_q, result_d;
  logic                       done_q, done_d;
  logic [element_width-1:0]   row_a [NOE];
  logic [element_width-1:0]   row_b [NOE];

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  // Vector buffer: no reset, writes only land while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle) && (32'(wr_addr) < NOE)) begin
      if (wr_row) row_b[wr_addr] <= wr_data;
      else        row_a[wr_addr] <= wr_data;
    end
  end

  // Package builder: slot 0 in the MSBs, indices past NOE read as zero.
  always_comb begin
    int unsigned e;
    e      = 0;
    pack_a = '0;
    pack_b = '0;
    for (int unsigned j = 0; j < NI; j++) begin
      e = 32'(load_idx) * NI + j;
      if (e < NOE) begin
        pack_a[element_width*(NI-j)-1 -: element_width] = row_a[AddrW'(e)];
        pack_b[element_width*(NI-j)-1 -: element_width] = row_b[AddrW'(e)];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pkg_d    = pkg_q;
    phase_d  = phase_q;
    load     = 1'b0;
    load_idx = '0;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    err_d    = err_q;
    wd_d     = (state_q == StWaitFin) ? wd_q + 1'b1 : '0;
`endif
    case (state_q)
      StIdle: begin
        if (start) state_d = StEngRst;
      end
      StEngRst: begin
        // Package 0 must already be on the buses during the FIRE cycle.
        load     = 1'b1;
        load_idx = '0;
        pkg_d    = '0;
        phase_d  = 1'b0;
        state_d  = StFire;
      end
      StFire: begin
        phase_d = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (pkg_q == PkgW'(P - 1)) begin
          state_d = StWaitFin;
        end else begin
          pkg_d    = pkg_q + 1'b1;
          load     = 1'b1;
          load_idx = pkg_q + 1'b1;
          phase_d  = 1'b0;
        end
      end
      StWaitFin: begin
        if (finish) begin
          result_d = dot_product_output;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (wd_q == WdW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pkg_q    <= '0;
      phase_q  <= 1'b0;
      bus_a_q  <= '0;
      bus_b_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pkg_q    <= pkg_d;
      phase_q  <= phase_d;
      result_q <= result_d;
      done_q   <= done_d;
      if (load) begin
        bus_a_q <= pack_a;
        bus_b_q <= pack_b;
      end
`ifdef FEEDER_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign busy              = (state_q != StIdle);
  assign outsider_read_now = (state_q == StFire);
  assign engine_reset      = reset | (state_q == StEngRst);
  assign first_row_input   = bus_a_q;
  assign second_row_input  = bus_b_q;
  assign result            = result_q;
  assign done              = done_q;
`ifdef FEEDER_TIMEOUT_EN
  assign timeout_err       = err_q;
`else
  assign timeout_err       = 1'b0;
`endif

endmodule

// File: tb/tb_complex_dot_product_feeder.sv
// Scoreboard bench: stimulus queues expected packages/results, a monitor compares on DUT outputs.
module tb_complex_dot_product_feeder;

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 256;
`endif
  localparam int P8 = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0, wr_row = 1'b0, start = 1'b0, finish = 1'b0;
  logic [2:0]   wr_addr = '0;
  logic [63:0]  wr_data = '0, dpo = '0;
  logic         busy, ornow, eng_rst, done, terr;
  logic [511:0] fri, sri;
  logic [63:0]  result;

  logic         wr_en12 = 1'b0, wr_row12 = 1'b0, start12 = 1'b0;
  logic [3:0]   wr_addr12 = '0;
  logic [63:0]  wr_data12 = '0;
  logic         busy12, ornow12, eng_rst12, done12, terr12;
  logic [511:0] fri12, sri12;
  logic [63:0]  result12;

  int total = 0;
  int bad = 0;
  logic [511:0] exp_a_q[$], exp_b_q[$];
  logic [63:0]  exp_res_q[$];
  logic [63:0]  ma[16], mb[16], ma12[16], mb12[16];

  always #5 clk = ~clk;

  complex_dot_product_feeder #(
    .element_width(64), .NOE(8), .NI(8), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .first_row_input(fri),
    .second_row_input(sri), .outsider_read_now(ornow), .engine_reset(eng_rst),
    .finish(finish), .dot_product_output(dpo), .result(result), .done(done),
    .timeout_err(terr)
  );

  complex_dot_product_feeder #(
    .element_width(64), .NOE(12), .NI(8), .TIMEOUT(TO)
  ) u_dut12 (
    .clk(clk), .reset(reset), .wr_en(wr_en12), .wr_row(wr_row12), .wr_addr(wr_addr12),
    .wr_data(wr_data12), .start(start12), .busy(busy12), .first_row_input(fri12),
    .second_row_input(sri12), .outsider_read_now(ornow12), .engine_reset(eng_rst12),
    .finish(1'b0), .dot_product_output(64'h0), .result(result12), .done(done12),
    .timeout_err(terr12)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slot 0 is shifted in first so it ends up in the MSBs.
  function automatic logic [511:0] pack(input logic [63:0] m[16], input int noe, input int k);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r = {r[447:0], ((k * 8 + j) < noe) ? m[k*8+j] : 64'h0};
    return r;
  endfunction

  task automatic push_pkgs();
    for (int k = 0; k < P8; k++) begin
      for (int c = 0; c < 2; c++) begin
        exp_a_q.push_back(pack(ma, 8, k));
        exp_b_q.push_back(pack(mb, 8, k));
      end
    end
  endtask

  task automatic wr(input logic row, input logic [2:0] addr, input logic [63:0] data);
    wr_en = 1'b1; wr_row = row; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr12(input logic row, input logic [3:0] addr, input logic [63:0] data);
    wr_en12 = 1'b1; wr_row12 = row; wr_addr12 = addr; wr_data12 = data;
    tick();
    wr_en12 = 1'b0;
  endtask

  // Monitor: package stream starts on the read strobe and lasts 2*P cycles.
  initial begin
    int left;
    logic [511:0] ea, eb;
    logic [63:0]  er;
    left = 0;
    forever begin
      @(negedge clk);
      if (ornow || left > 0) begin
        if (exp_a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pkg_unexpected: got %0h want none", fri);
        end else begin
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          check("pkg_row_a", fri, ea);
          check("pkg_row_b", sri, eb);
        end
        left = ornow ? 2 * P8 - 1 : left - 1;
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got result %0h want no done", result);
        end else begin
          er = exp_res_q.pop_front();
          check("result", result, er);
        end
      end
      if (reset) begin
        left = 0;
        exp_a_q.delete();
        exp_b_q.delete();
      end
    end
  end

  initial begin
    logic [511:0] hand;
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0; mb[i] = '0; ma12[i] = '0; mb12[i] = '0;
    end

    // Reset state
    tick(); tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_read", ornow, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_terr", terr, 0);
    check("rst_bus_a", fri, 0);
    check("rst_bus_b", sri, 0);
    check("rst_eng_rst", eng_rst, 1);
    reset = 1'b0;
    tick();
    check("idle_eng_rst", eng_rst, 0);

    for (int e = 0; e < 8; e++) begin
      ma[e] = 64'(e + 1) << 32;
      mb[e] = 64'h1 << 32;
      wr(1'b0, 3'(e), ma[e]);
      wr(1'b1, 3'(e), mb[e]);
    end

    // Run 1: basic transfer, finish at S+20
    push_pkgs();
    start = 1'b1;
    tick();                                   // S+1
    start = 1'b0;
    check("r1_eng_rst", eng_rst, 1);
    check("r1_busy", busy, 1);
    check("r1_read_early", ornow, 0);
    tick();                                   // S+2
    check("r1_read", ornow, 1);
    tick();                                   // S+3
    check("r1_read_pulse", ornow, 0);
    for (int i = 0; i < 17; i++) tick();      // S+20
    check("r1_busy_wait", busy, 1);
    finish = 1'b1; dpo = 64'h24;
    exp_res_q.push_back(64'h24);
    tick();                                   // S+21
    finish = 1'b0;
    check("r1_done", done, 1);
    check("r1_busy_fall", busy, 0);
    check("r1_bus_hold", fri, 0);
    tick();
    check("r1_done_pulse", done, 0);
    finish = 1'b1;                            // ignored in IDLE
    tick();
    finish = 1'b0;
    check("idle_finish_ignored", done, 0);

    // Run 2: finish in STREAM ignored, write while busy dropped, start held
    push_pkgs();
    start = 1'b1;
    tick(); tick(); tick();                   // S+3
    finish = 1'b1;
    tick();                                   // S+4
    finish = 1'b0;
    check("r2_stream_finish_ignored", done, 0);
    wr_en = 1'b1; wr_row = 1'b0; wr_addr = 3'd0; wr_data = 64'hFF;
    tick();                                   // S+5
    wr_en = 1'b0;
    tick(); tick();                           // S+7
    check("r2_still_busy", busy, 1);
    finish = 1'b1; dpo = 64'h99;
    exp_res_q.push_back(64'h99);
    tick();                                   // S+8 = S3
    finish = 1'b0;
    check("r2_done", done, 1);
    check("r2_idle", busy, 0);
    push_pkgs();
    tick();                                   // S3+1
    start = 1'b0;
    check("r3_retrigger", eng_rst, 1);
    tick();                                   // S3+2
    check("r3_read", ornow, 1);
    hand = fri;
    check("r3_slot0_kept", hand[511:448], 64'h1 << 32);
    tick();                                   // S3+3
    reset = 1'b1;
    tick();                                   // S3+4
    check("midrst_busy", busy, 0);
    check("midrst_eng_rst", eng_rst, 1);
    check("midrst_read", ornow, 0);
    check("midrst_bus_a", fri, 0);
    check("midrst_bus_b", sri, 0);
    check("midrst_result", result, 0);
    reset = 1'b0;
    tick();

`ifdef FEEDER_TIMEOUT_EN
    // Run 4: watchdog expiry with no finish
    push_pkgs();
    start = 1'b1;
    tick();                                   // S+1
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();      // S+21 = WAIT_FIN+15
    check("to_not_yet", terr, 0);
    check("to_busy", busy, 1);
    tick();                                   // WAIT_FIN+16
    check("to_err", terr, 1);
    check("to_idle", busy, 0);
    check("to_no_done", done, 0);
    check("to_result", result, 0);
    tick();
    check("to_sticky", terr, 1);
`endif

    // NOE=12: second package is A[8..11] then zeros
    for (int e = 0; e < 12; e++) begin
      ma12[e] = 64'h100 + 64'(e);
      mb12[e] = 64'h200 + 64'(e);
      wr12(1'b0, 4'(e), ma12[e]);
      wr12(1'b1, 4'(e), mb12[e]);
    end
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    tick();                                   // S+2
    check("n12_read", ornow12, 1);
    check("n12_pkg0_a", fri12, pack(ma12, 12, 0));
    check("n12_pkg0_b", sri12, pack(mb12, 12, 0));
    tick(); tick();                           // S+4
    hand = {64'h108, 64'h109, 64'h10a, 64'h10b, 256'h0};
    check("n12_pkg1_a", fri12, hand);
    hand = {64'h208, 64'h209, 64'h20a, 64'h20b, 256'h0};
    check("n12_pkg1_b", sri12, hand);
    tick(); tick(); tick();                   // S+7, WAIT_FIN
    check("n12_hold_a", fri12, {64'h108, 64'h109, 64'h10a, 64'h10b, 256'h0});
    check("n12_busy", busy12, 1);

    tick();
    check("leftover_pkgs", exp_a_q.size(), 0);
    check("leftover_results", exp_res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
